// File: rtl/avalon_burst_copier.sv
// Avalon-MM write master: copies NUM_WORDS samples from a synchronous source buffer
// to strided destination addresses, then writes a done/error status word.
module avalon_burst_copier #(
  parameter int unsigned             DATA_W     = 16,
  parameter int unsigned             ADDR_W     = 10,
  parameter int unsigned             SRC_AW     = 9,
  parameter int unsigned             NUM_WORDS  = 512,
  parameter int unsigned             DST_BASE   = 0,
  parameter int unsigned             DST_STRIDE = 1,
  parameter logic [ADDR_W-1:0]       STAT_ADDR  = 10'h2FF,
  parameter logic [DATA_W-1:0]       DONE_DATA  = 16'h0042,
  parameter logic [DATA_W-1:0]       ERR_DATA   = 16'h00EE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              src_re,
  output logic [SRC_AW-1:0] src_addr,
  input  logic [DATA_W-1:0] src_data,
  output logic              master_write,
  output logic [ADDR_W-1:0] master_address,
  output logic [DATA_W-1:0] master_write_data,
  input  logic              master_waitrequest,
  input  logic [1:0]        master_response,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [SRC_AW:0]   words_done
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, STAT} state_t;

  localparam logic [SRC_AW-1:0] LAST_IDX = SRC_AW'(NUM_WORDS - 1);

  state_t              state_q, state_d;
  logic [SRC_AW-1:0]   idx_q, idx_d;
  logic                src_re_q, src_re_d;
  logic [SRC_AW-1:0]   src_addr_q, src_addr_d;
  logic                mwrite_q, mwrite_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [DATA_W-1:0]   mdata_q, mdata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [SRC_AW:0]     words_done_q, words_done_d;

  logic                accept;
  logic [ADDR_W-1:0]   dst_addr;

  assign accept   = mwrite_q & ~master_waitrequest;
  // Truncation to ADDR_W gives the modulo-2**ADDR_W wrap for free.
  assign dst_addr = ADDR_W'(DST_BASE) + ADDR_W'(ADDR_W'(idx_q) * ADDR_W'(DST_STRIDE));

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    maddr_d      = maddr_q;
    mdata_d      = mdata_q;
    err_d        = err_q;
    words_done_d = words_done_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d      = FETCH;
        idx_d        = '0;
        words_done_d = '0;
        err_d        = 1'b0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = WRITE;
        maddr_d = dst_addr;
        mdata_d = src_data;
      end
      WRITE: if (accept) begin
        if (master_response != 2'b00) begin
          err_d   = 1'b1;
          state_d = STAT;
        end else begin
          words_done_d = words_done_q + (SRC_AW+1)'(1);
          idx_d        = idx_q + SRC_AW'(1);
          state_d      = (idx_q == LAST_IDX) ? STAT : FETCH;
        end
      end
      STAT: if (accept) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == STAT && state_q != STAT) begin
      maddr_d = STAT_ADDR;
      mdata_d = err_d ? ERR_DATA : DONE_DATA;
    end
    // Outputs are registered from the next state so they line up with it.
    mwrite_d   = (state_d == WRITE) || (state_d == STAT);
    src_re_d   = (state_d == FETCH);
    src_addr_d = idx_d;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      src_re_q     <= 1'b0;
      src_addr_q   <= '0;
      mwrite_q     <= 1'b0;
      maddr_q      <= '0;
      mdata_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      src_re_q     <= src_re_d;
      src_addr_q   <= src_addr_d;
      mwrite_q     <= mwrite_d;
      maddr_q      <= maddr_d;
      mdata_q      <= mdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      words_done_q <= words_done_d;
    end
  end

  assign src_re            = src_re_q;
  assign src_addr          = src_addr_q;
  assign master_write      = mwrite_q;
  assign master_address    = maddr_q;
  assign master_write_data = mdata_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign words_done        = words_done_q;

endmodule

// File: tb/tb_avalon_burst_copier.sv
// Scoreboard bench for avalon_burst_copier: random source data, scripted/random slave
// stalls and error responses, expected writes queued at start and popped on accept.
module tb_avalon_burst_copier;
  localparam int DW = 16, AW = 10, SAW = 9, N = 4;
  localparam int BASE = 'h3FE, STRIDE = 1;
  localparam logic [AW-1:0] STAT_A = 10'h2FF;
  localparam logic [DW-1:0] DONE_D = 16'h0042, ERR_D = 16'h00EE;

  logic clk = 0, rst = 1, start = 0;
  logic src_re;
  logic [SAW-1:0] src_addr;
  logic [DW-1:0] src_data = '0;
  logic master_write;
  logic [AW-1:0] master_address;
  logic [DW-1:0] master_write_data;
  logic wr = 0;
  logic [1:0] resp = 0;
  logic busy, done, err;
  logic [SAW:0] words_done;

  avalon_burst_copier #(.DATA_W(DW), .ADDR_W(AW), .SRC_AW(SAW), .NUM_WORDS(N),
    .DST_BASE(BASE), .DST_STRIDE(STRIDE), .STAT_ADDR(STAT_A),
    .DONE_DATA(DONE_D), .ERR_DATA(ERR_D)) dut (
    .clk(clk), .rst(rst), .start(start), .src_re(src_re), .src_addr(src_addr),
    .src_data(src_data), .master_write(master_write), .master_address(master_address),
    .master_write_data(master_write_data), .master_waitrequest(wr),
    .master_response(resp), .busy(busy), .done(done), .err(err), .words_done(words_done));

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:2**SAW-1];
  always @(posedge clk) if (src_re) src_data <= mem[src_addr];

  typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; logic st; } wr_t;
  wr_t exp_q[$];

  int compared = 0, mismatched = 0;
  int cyc = 0, acc_cnt = 0, done_cnt = 0, stall_seen = 0, last_data_cyc = -1;
  int err_word = -1, stall_word = -1, stall_left = 0;
  bit rand_wait = 0, nostall_chk = 0, hold_prev = 0;
  logic [AW-1:0] h_a;
  logic [DW-1:0] h_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave: waitrequest/response are set just after the edge for the coming cycle.
  always @(posedge clk) begin
    #1;
    if (stall_word >= 0 && acc_cnt == stall_word && master_write && stall_left > 0) begin
      wr = 1; stall_left--;
    end else if (rand_wait) wr = ($urandom_range(0, 2) == 0);
    else wr = 0;
    resp = (acc_cnt == err_word) ? 2'b10 : 2'b00;
  end

  // Monitor: pops the scoreboard on every accepted write.
  always @(negedge clk) begin
    if (rst) hold_prev = 0;
    else begin
      if (done) done_cnt++;
      if (hold_prev) begin
        chk("hold_write", {31'd0, master_write}, 1);
        chk("hold_addr", 32'(master_address), 32'(h_a));
        chk("hold_data", 32'(master_write_data), 32'(h_d));
      end
      hold_prev = master_write && wr;
      if (hold_prev) begin h_a = master_address; h_d = master_write_data; stall_seen++; end
      if (master_write && !wr) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                   master_address, master_write_data);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk(e.st ? "stat_addr" : "wr_addr", 32'(master_address), 32'(e.a));
          chk(e.st ? "stat_data" : "wr_data", 32'(master_write_data), 32'(e.d));
          if (nostall_chk && !e.st && last_data_cyc >= 0) chk("spacing", cyc - last_data_cyc, 3);
          if (!e.st) last_data_cyc = cyc;
        end
        acc_cnt++;
      end
    end
  end

  task automatic prep(input int ew, input int sw, input int sl, input bit rw);
    int nw;
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
    err_word = ew; stall_word = sw; stall_left = sl; rand_wait = rw;
    nostall_chk = !rw && sw < 0;
    acc_cnt = 0; done_cnt = 0; last_data_cyc = -1; stall_seen = 0;
    exp_q.delete();
    nw = (ew >= 0) ? ew + 1 : N;
    for (int i = 0; i < nw; i++) exp_q.push_back({AW'((BASE + i * STRIDE) % (1 << AW)), mem[i], 1'b0});
    exp_q.push_back({STAT_A, (ew >= 0) ? ERR_D : DONE_D, 1'b1});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic do_xfer(input int ew, input int sw, input int sl, input bit rw, input int extra);
    int t;
    prep(ew, sw, sl, rw);
    pulse_start();
    @(negedge clk) chk("busy_after_start", {31'd0, busy}, 1);
    for (int k = 0; k < extra; k++) pulse_start();
    t = 0;
    while (done_cnt == 0 && t < 2000) begin @(posedge clk); t++; end
    if (done_cnt == 0) begin
      compared++; mismatched++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
    repeat (5) @(posedge clk);
    #2;
    chk("queue_empty", exp_q.size(), 0);
    chk("done_pulses", done_cnt, 1);
    chk("words_done", 32'(words_done), (ew >= 0) ? ew : N);
    chk("err", {31'd0, err}, (ew >= 0) ? 1 : 0);
    chk("busy_idle", {31'd0, busy}, 0);
    if (sw >= 0) chk("stall_cycles", stall_seen, sl);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_write", {31'd0, master_write}, 0);
    chk("rst_src_re", {31'd0, src_re}, 0);
    chk("rst_addr", 32'(master_address), 0);
    chk("rst_busy_done_err", {29'd0, busy, done, err}, 0);
    chk("rst_words_done", 32'(words_done), 0);
    rst = 0;

    do_xfer(-1, -1, 0, 0, 0);   // plain transfer, 3-cycle spacing, address wrap
    do_xfer(-1, 2, 5, 0, 0);    // 5-cycle stall on word 2
    do_xfer(1, -1, 0, 0, 0);    // error response on word 1
    do_xfer(0, -1, 0, 1, 0);    // error on first word, random stalls
    do_xfer(N - 1, -1, 0, 1, 0);

    // Reset in the middle of the second data write.
    prep(-1, -1, 0, 0);
    pulse_start();
    t = 0;
    while (!(acc_cnt == 1 && master_write) && t < 200) begin @(posedge clk); #2; t++; end
    chk("reached_mid_write", {31'd0, master_write}, 1);
    rst = 1;
    #1;
    chk("rst_mid_write", {31'd0, master_write}, 0);
    chk("rst_mid_busy", {31'd0, busy}, 0);
    chk("rst_mid_words", 32'(words_done), 0);
    @(posedge clk); #1 rst = 0;
    do_xfer(-1, -1, 0, 0, 0);

    do_xfer(-1, -1, 0, 0, 3);   // starts while busy are ignored
    for (int r = 0; r < 6; r++)
      do_xfer(($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, N - 1)), -1, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
